// File: rtl/mult_prod_accum.sv
// rtl/mult_prod_accum.sv - accumulates multiplier product beats per vector into a held sum/count/overflow result
module mult_prod_accum #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   res_sum_q, res_sum_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic               res_ovf_q, res_ovf_d;

    logic               accept;
    logic               out_hs;
    logic [ACC_W:0]     sum_ext;
    logic [CNT_W-1:0]   cnt_inc;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !clr;
    assign out_hs    = out_valid && out_ready;
    assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

    assign out_sum   = res_sum_q;
    assign out_count = res_cnt_q;
    assign out_ovf   = res_ovf_q;

    // acc/cnt/ovf are already zero while a result is held, so a beat taken during
    // the result handshake naturally starts the next vector from zero.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_sum_d = res_sum_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (out_hs) begin
                state_d = ACCUM;
            end
            if (accept) begin
                if (in_last) begin
                    res_sum_d = sum_ext[ACC_W-1:0];
                    res_cnt_d = cnt_inc;
                    res_ovf_d = ovf_q || sum_ext[ACC_W];
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = HOLD;
                end else begin
                    acc_d = sum_ext[ACC_W-1:0];
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q || sum_ext[ACC_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_sum_q <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_sum_q <= res_sum_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
        end
    end

endmodule
